// File: rtl/io_uart_pkg.sv
// Shared constants for the IO-bus UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package io_uart_pkg;

   localparam logic [1:0] OFS_TXDATA = 2'd0;
   localparam logic [1:0] OFS_STATUS = 2'd1;
   localparam logic [1:0] OFS_DIV    = 2'd2;

   localparam int ST_EMPTY_BIT = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   function automatic logic [15:0] pack_status(input logic ovf, input logic busy,
                                               input logic full, input logic empty);
      logic [15:0] s;
      s = '0;
      s[ST_OVF_BIT]   = ovf;
      s[ST_BUSY_BIT]  = busy;
      s[ST_FULL_BIT]  = full;
      s[ST_EMPTY_BIT] = empty;
      return s;
   endfunction

endpackage

// File: rtl/io_uart_tx_responder_sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/io_uart_tx_responder.sv
// IO-bus responder: 4-port register window feeding a TX FIFO and an 8N1
// serialiser. io_ack pulses one cycle after any in-window access; io_rdata is valid in that cycle.
module io_uart_tx_responder
   import io_uart_pkg::*;
#(
   parameter logic [15:0] BASE_PORT  = 16'h0010,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_enable,
   input  logic        io_rw,
   input  logic [15:0] io_port,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   output logic        io_ack,
   output logic        tx,
   output logic        tx_idle,
   output tx_state_e   dbg_state
);

   tx_state_e   state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        overflow_q, overflow_d;
   logic        io_ack_q, io_ack_d;
   logic [15:0] io_rdata_q, io_rdata_d;

   logic        in_win, wr_acc, rd_acc;
   logic [1:0]  ofs;
   logic        push_req, fifo_pop, fifo_full, fifo_empty, dropped;
   logic [7:0]  fifo_rdata;
   logic        busy, bit_end;

   assign in_win   = io_enable && (io_port[15:2] == BASE_PORT[15:2]);
   assign ofs      = io_port[1:0];
   assign wr_acc   = in_win && io_rw;
   assign rd_acc   = in_win && !io_rw;
   assign push_req = wr_acc && (ofs == OFS_TXDATA);
   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;
   assign dropped  = push_req && fifo_full && !fifo_pop;
   assign busy     = (state_q != S_IDLE);
   assign bit_end  = (cnt_q == 16'd0);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_req),
      .wdata (io_wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      io_ack_d   = in_win;
      io_rdata_d = io_rdata_q;
      div_d      = div_q;
      overflow_d = overflow_q;
      if (rd_acc) begin
         case (ofs)
            OFS_STATUS: io_rdata_d = pack_status(overflow_q, busy, fifo_full, fifo_empty);
            OFS_DIV:    io_rdata_d = div_q;
            default:    io_rdata_d = 16'd0;
         endcase
      end
      if (wr_acc && (ofs == OFS_DIV)) div_d = (io_wdata == 16'd0) ? 16'd1 : io_wdata;
      if (rd_acc && (ofs == OFS_STATUS)) overflow_d = 1'b0;
      // A fresh drop in the same cycle as the clearing read keeps the flag set.
      if (dropped) overflow_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (state_q != S_IDLE) cnt_d = bit_end ? (div_q - 16'd1) : (cnt_q - 16'd1);
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_START;
               shift_d = fifo_rdata;
               cnt_d   = div_q - 16'd1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) state_d = S_STOP;
               else bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         S_STOP: begin
            if (bit_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         div_q      <= DIV_RESET;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
         io_ack_q   <= 1'b0;
         io_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
         io_ack_q   <= io_ack_d;
         io_rdata_q <= io_rdata_d;
      end
   end

   assign tx        = tx_q;
   assign io_ack    = io_ack_q;
   assign io_rdata  = io_rdata_q;
   assign tx_idle   = fifo_empty && (state_q == S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_io_uart_tx_responder.sv
// Directed bench for io_uart_tx_responder: register access, frame timing,
// FIFO overflow, divisor changes, window decode and asynchronous reset.
module tb_io_uart_tx_responder;
   import io_uart_pkg::*;

   localparam logic [15:0] BASE = 16'h0010;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        io_enable = 1'b0;
   logic        io_rw = 1'b0;
   logic [15:0] io_port = '0;
   logic [15:0] io_wdata = '0;
   logic [15:0] io_rdata;
   logic        io_ack, tx, tx_idle;
   tx_state_e   dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   io_uart_tx_responder #(
      .BASE_PORT  (BASE),
      .FIFO_DEPTH (4),
      .DIV_RESET  (16'd868)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .io_enable (io_enable),
      .io_rw     (io_rw),
      .io_port   (io_port),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata),
      .io_ack    (io_ack),
      .tx        (tx),
      .tx_idle   (tx_idle),
      .dbg_state (dbg_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic rw, input logic [15:0] port, input logic [15:0] wd);
      io_enable = 1'b1;
      io_rw     = rw;
      io_port   = port;
      io_wdata  = wd;
      step();
      io_enable = 1'b0;
      io_rw     = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [15:0] port, input logic [15:0] wd,
                     input logic exp_ack);
      access(1'b1, port, wd);
      chk({tag, "_ack"}, {15'd0, io_ack}, {15'd0, exp_ack});
   endtask

   task automatic rd(input string tag, input logic [15:0] port, input logic exp_ack,
                     input logic [15:0] exp_data);
      access(1'b0, port, 16'd0);
      chk({tag, "_ack"}, {15'd0, io_ack}, {15'd0, exp_ack});
      chk({tag, "_rdata"}, io_rdata, exp_data);
   endtask

   task automatic wait_state(input string tag, input tx_state_e s, input int limit);
      int n = 0;
      while (dbg_state != s && n < limit) begin
         step();
         n++;
      end
      chk({tag, "_reached"}, {14'd0, dbg_state}, {14'd0, s});
   endtask

   // Checks one frame cycle by cycle; ends on the first cycle after the stop bit.
   task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                              input int max_wait);
      int waited = 0;
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      while (tx !== 1'b0 && waited < max_wait) begin
         step();
         waited++;
      end
      chk({tag, "_start"}, {15'd0, tx}, 16'd0);
      for (int i = 1; i < 10 * div; i++) begin
         step();
         chk(tag, {15'd0, tx}, {15'd0, fr[i / div]});
      end
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       exp_bit;

      // Reset state
      repeat (3) step();
      chk("rst_tx", {15'd0, tx}, 16'd1);
      chk("rst_tx_idle", {15'd0, tx_idle}, 16'd1);
      chk("rst_ack", {15'd0, io_ack}, 16'd0);
      chk("rst_rdata", io_rdata, 16'd0);
      reset = 1'b1;
      step();
      rd("rst_status", BASE + 16'd1, 1'b1, 16'h0001);
      rd("rst_div", BASE + 16'd2, 1'b1, 16'd868);

      // DIV=4, one byte 0xA5
      wr("div4", BASE + 16'd2, 16'd4, 1'b1);
      wr("push_a5", BASE, 16'h00A5, 1'b1);
      chk("a5_pre_tx", {15'd0, tx}, 16'd1);
      step();
      chk("a5_ack_pulse", {15'd0, io_ack}, 16'd0);
      check_frame("a5", 8'hA5, 4, 0);
      chk("a5_end_tx", {15'd0, tx}, 16'd1);
      chk("a5_end_idle", {15'd0, tx_idle}, 16'd1);

      // DIV=1, overflow while busy, push-when-full-with-pop
      wr("div1", BASE + 16'd2, 16'd1, 1'b1);
      wr("push_11", BASE, 16'h0011, 1'b1);
      wr("push_22", BASE, 16'h0022, 1'b1);
      wr("push_33", BASE, 16'h0033, 1'b1);
      wr("push_44", BASE, 16'h0044, 1'b1);
      wr("push_55", BASE, 16'h0055, 1'b1);
      wr("push_66_drop", BASE, 16'h0066, 1'b1);
      rd("ovf_status", BASE + 16'd1, 1'b1, 16'h000E);
      rd("ovf_cleared", BASE + 16'd1, 1'b1, 16'h0006);
      wait_state("idle_11", S_IDLE, 40);
      wr("push_66_pop", BASE, 16'h0066, 1'b1);
      rd("full_pop_status", BASE + 16'd1, 1'b1, 16'h0006);
      wait_state("idle_22", S_IDLE, 40);
      check_frame("f33", 8'h33, 1, 1);
      check_frame("f44", 8'h44, 1, 1);
      check_frame("f55", 8'h55, 1, 1);
      check_frame("f66", 8'h66, 1, 1);
      chk("drain_idle", {15'd0, tx_idle}, 16'd1);
      rd("drain_status", BASE + 16'd1, 1'b1, 16'h0001);

      // Two bytes back to back at DIV=2
      wr("div2", BASE + 16'd2, 16'd2, 1'b1);
      wr("push_c3", BASE, 16'h00C3, 1'b1);
      wr("push_5a", BASE, 16'h005A, 1'b1);
      check_frame("c3", 8'hC3, 2, 0);
      chk("gap_tx", {15'd0, tx}, 16'd1);
      chk("gap_not_idle", {15'd0, tx_idle}, 16'd0);
      step();
      check_frame("5a", 8'h5A, 2, 0);
      chk("pair_idle", {15'd0, tx_idle}, 16'd1);

      // DIV 4->8 written during data bit 3
      wr("div4b", BASE + 16'd2, 16'd4, 1'b1);
      wr("push_69", BASE, 16'h0069, 1'b1);
      step();
      d = 8'h69;
      for (int i = 0; i < 60; i++) begin
         if (i < 4)       exp_bit = 1'b0;
         else if (i < 20) exp_bit = d[(i - 4) / 4];
         else if (i < 52) exp_bit = d[4 + (i - 20) / 8];
         else             exp_bit = 1'b1;
         chk("div_chg_tx", {15'd0, tx}, {15'd0, exp_bit});
         if (i == 18) chk("div_chg_ack", {15'd0, io_ack}, 16'd1);
         if (i == 17) begin
            io_enable = 1'b1;
            io_rw     = 1'b1;
            io_port   = BASE + 16'd2;
            io_wdata  = 16'd8;
         end else begin
            io_enable = 1'b0;
            io_rw     = 1'b0;
         end
         step();
      end
      chk("div_chg_idle", {15'd0, tx_idle}, 16'd1);
      rd("div8", BASE + 16'd2, 1'b1, 16'd8);
      wr("div0", BASE + 16'd2, 16'd0, 1'b1);
      rd("div0_reads_1", BASE + 16'd2, 1'b1, 16'd1);

      // Window decode
      wr("div123", BASE + 16'd2, 16'h0123, 1'b1);
      rd("rsvd_rd", BASE + 16'd3, 1'b1, 16'd0);
      wr("rsvd_wr", BASE + 16'd3, 16'hFFFF, 1'b1);
      rd("div_after_rsvd", BASE + 16'd2, 1'b1, 16'h0123);
      wr("oow_p4_wr", BASE + 16'd4, 16'h00AB, 1'b0);
      wr("oow_m1_wr", BASE - 16'd1, 16'h0077, 1'b0);
      wr("oow_m2_wr", BASE - 16'd2, 16'h0005, 1'b0);
      rd("oow_p4_rd", BASE + 16'd4, 1'b0, 16'h0123);
      rd("oow_m1_rd", BASE - 16'd1, 1'b0, 16'h0123);
      chk("oow_tx", {15'd0, tx}, 16'd1);
      chk("oow_tx_idle", {15'd0, tx_idle}, 16'd1);
      rd("oow_status", BASE + 16'd1, 1'b1, 16'h0001);
      rd("oow_div", BASE + 16'd2, 1'b1, 16'h0123);

      // Reset in the middle of a frame with a byte still queued
      wr("div4c", BASE + 16'd2, 16'd4, 1'b1);
      wr("push_81", BASE, 16'h0081, 1'b1);
      wr("push_42", BASE, 16'h0042, 1'b1);
      wait_state("mid_data", S_DATA, 20);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_tx", {15'd0, tx}, 16'd1);
      chk("mid_rst_idle", {15'd0, tx_idle}, 16'd1);
      chk("mid_rst_ack", {15'd0, io_ack}, 16'd0);
      chk("mid_rst_rdata", io_rdata, 16'd0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 45; i++) begin
         step();
         chk("post_rst_tx", {15'd0, tx}, 16'd1);
      end
      rd("post_rst_status", BASE + 16'd1, 1'b1, 16'h0001);
      rd("post_rst_div", BASE + 16'd2, 1'b1, 16'd868);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
